fb_write_arbiter: RTL and testbench

//  Shares the single framebuffer write port among the drawing engines fed by the command broadcast
//  (line draw, test pattern, rect fill, circle, ellipse). Uses round-robin arbitration with per-primitive

---
 rtl/fb_write_arbiter_pkg.sv | 21 ++
 rtl/fb_write_arbiter_if.sv | 36 +++
 rtl/fb_write_arbiter_rr_pick.sv | 40 ++++
 rtl/fb_write_arbiter.sv | 145 ++++++++++++++
 tb/tb_fb_write_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fb_write_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// fb_write_arbiter_pkg : shared graphics defines (engine ids, FB bus widths)
// Rev 1.0
// ============================================================================
package fb_write_arbiter_pkg;

  // Engine indices as seen on the arbiter request vector
  localparam int ENG_LINE    = 0;
  localparam int ENG_TESTPAT = 1;
  localparam int ENG_RECT    = 2;
  localparam int ENG_CIRCLE  = 3;
  localparam int ENG_ELLIPSE = 4;

  localparam int NUM_ENGINES = 5;
  localparam int FB_ADDR_W   = 19;
  localparam int FB_DATA_W   = 8;
  localparam int GRANT_W     = 3;

endpackage : fb_write_arbiter_pkg
`default_nettype wire

// File: rtl/fb_write_arbiter_if.sv
`default_nettype none
// ============================================================================
// fb_write_arbiter_if : engine request bundle plus framebuffer write bus
// Rev 1.0
// ============================================================================
interface fb_write_arbiter_if
  import fb_write_arbiter_pkg::*;
#(
  parameter int NUM_REQ = NUM_ENGINES,
  parameter int ADDR_W  = FB_ADDR_W,
  parameter int DATA_W  = FB_DATA_W
) ();

  logic [NUM_REQ-1:0]        req_rts;
  logic [NUM_REQ-1:0]        req_rtr;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_last;
  logic                      fb_rts;
  logic                      fb_rtr;
  logic [ADDR_W-1:0]         fb_addr;
  logic [DATA_W-1:0]         fb_data;

  // master is the arbiter; slave is the engines plus the VRAM write controller
  modport master (
    input  req_rts, req_addr, req_data, req_last, fb_rtr,
    output req_rtr, fb_rts, fb_addr, fb_data
  );

  modport slave (
    output req_rts, req_addr, req_data, req_last, fb_rtr,
    input  req_rtr, fb_rts, fb_addr, fb_data
  );

endinterface : fb_write_arbiter_if
`default_nettype wire

// File: rtl/fb_write_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// rr_pick : combinational round-robin picker, searches ptr+1, ptr+2, ... mod N
// Rev 1.0
// ============================================================================
module rr_pick #(
  parameter int N  = 5,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [IW:0]   sum;
  logic [IW-1:0] j;
  logic          found;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    sum   = '0;
    j     = '0;
    for (int k = 1; k <= N; k++) begin
      sum = (IW+1)'(ptr) + (IW+1)'(k);
      j   = (sum >= (IW+1)'(N)) ? IW'(sum - (IW+1)'(N)) : IW'(sum);
      if (!found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = j;
      end
    end
    any = |req;
  end

endmodule : rr_pick
`default_nettype wire

// File: rtl/fb_write_arbiter.sv
`default_nettype none
// ============================================================================
// fb_write_arbiter : round-robin framebuffer write-port arbiter with
// per-primitive burst lock and a single-register output stage.   Rev 1.0
// ============================================================================
module fb_write_arbiter
  import fb_write_arbiter_pkg::*;
#(
  parameter int NUM_REQ   = NUM_ENGINES,
  parameter int ADDR_W    = FB_ADDR_W,
  parameter int DATA_W    = FB_DATA_W,
  parameter int MAX_BURST = 16,
  parameter int IDLE_TO   = 8
) (
  input  logic               clk,
  input  logic               rst_,
  input  logic               soft_reset,
  fb_write_arbiter_if.master bus,
  output logic [GRANT_W-1:0] grant_id,
  output logic               busy
);

  localparam int PW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int BW  = $clog2(MAX_BURST) + 1;
  localparam int IDW = $clog2(IDLE_TO + 1);

  localparam logic [0:0] ST_ARB  = 1'b0;
  localparam logic [0:0] ST_LOCK = 1'b1;

  logic [0:0]         state;
  logic [PW-1:0]      rr_ptr;
  logic [NUM_REQ-1:0] grant_oh;
  logic [BW-1:0]      burst_cnt;
  logic [IDW-1:0]     idle_cnt;
  logic               fb_rts_q;
  logic [ADDR_W-1:0]  fb_addr_q;
  logic [DATA_W-1:0]  fb_data_q;

  logic [NUM_REQ-1:0] pick_gnt;
  logic [PW-1:0]      pick_idx;
  logic               pick_any;

  logic [ADDR_W-1:0]  addr_arr [NUM_REQ];
  logic [DATA_W-1:0]  data_arr [NUM_REQ];
  logic [ADDR_W-1:0]  own_addr;
  logic [DATA_W-1:0]  own_data;
  logic               own_rts;
  logic               own_last;
  logic               lock;
  logic               can_take;
  logic               accept;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_arr[g] = bus.req_addr[g*ADDR_W +: ADDR_W];
    assign data_arr[g] = bus.req_data[g*DATA_W +: DATA_W];
  end

  rr_pick #(
    .N  (NUM_REQ),
    .IW (PW)
  ) u_pick (
    .req (bus.req_rts),
    .ptr (rr_ptr),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  assign own_addr = addr_arr[grant_id];
  assign own_data = data_arr[grant_id];
  assign own_rts  = |(bus.req_rts  & grant_oh);
  assign own_last = |(bus.req_last & grant_oh);
  assign lock     = (state == ST_LOCK);
  // The output register can take a beat when empty or draining this cycle
  assign can_take = !fb_rts_q | bus.fb_rtr;
  assign accept   = lock & own_rts & can_take;

  assign bus.req_rtr = grant_oh & {NUM_REQ{lock & can_take}};
  assign bus.fb_rts  = fb_rts_q;
  assign bus.fb_addr = fb_addr_q;
  assign bus.fb_data = fb_data_q;
  assign busy        = lock | fb_rts_q;

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state     <= ST_ARB;
      rr_ptr    <= PW'(NUM_REQ - 1);
      grant_oh  <= '0;
      grant_id  <= '0;
      burst_cnt <= '0;
      idle_cnt  <= '0;
      fb_rts_q  <= 1'b0;
      fb_addr_q <= '0;
      fb_data_q <= '0;
    end else if (soft_reset) begin
      // A held output beat is dropped, not delivered
      state     <= ST_ARB;
      rr_ptr    <= PW'(NUM_REQ - 1);
      grant_oh  <= '0;
      grant_id  <= '0;
      burst_cnt <= '0;
      idle_cnt  <= '0;
      fb_rts_q  <= 1'b0;
      fb_addr_q <= '0;
      fb_data_q <= '0;
    end else begin
      if (accept) begin
        fb_rts_q  <= 1'b1;
        fb_addr_q <= own_addr;
        fb_data_q <= own_data;
      end else if (bus.fb_rtr) begin
        fb_rts_q  <= 1'b0;
      end

      case (state)
        ST_ARB: begin
          if (pick_any) begin
            state     <= ST_LOCK;
            grant_oh  <= pick_gnt;
            grant_id  <= GRANT_W'(pick_idx);
            rr_ptr    <= pick_idx;
            burst_cnt <= '0;
            idle_cnt  <= '0;
          end
        end
        ST_LOCK: begin
          if (accept) begin
            burst_cnt <= burst_cnt + 1'b1;
            idle_cnt  <= '0;
            if (own_last || (burst_cnt == BW'(MAX_BURST - 1)))
              state <= ST_ARB;
          end else if (!own_rts) begin
            // Stalled-but-requesting cycles do not count as idle
            idle_cnt <= idle_cnt + 1'b1;
            if (idle_cnt == IDW'(IDLE_TO - 1))
              state <= ST_ARB;
          end
        end
        default: state <= ST_ARB;
      endcase
    end
  end

endmodule : fb_write_arbiter
`default_nettype wire

// File: tb/tb_fb_write_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_fb_write_arbiter : scoreboard bench for the framebuffer write arbiter
// Rev 1.0
// ============================================================================
module tb_fb_write_arbiter;
  import fb_write_arbiter_pkg::*;

  localparam int N  = 5;
  localparam int AW = 19;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst_ = 1'b0;
  logic soft_reset = 1'b0;
  logic [GRANT_W-1:0] grant_id;
  logic busy;

  fb_write_arbiter_if #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

  fb_write_arbiter #(
    .NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .MAX_BURST(16), .IDLE_TO(8)
  ) dut (
    .clk        (clk),
    .rst_       (rst_),
    .soft_reset (soft_reset),
    .bus        (bus),
    .grant_id   (grant_id),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  int rem [N];
  int seq [N];
  bit use_last [N];
  int fire_cyc [N];
  logic [31:0] sb [N][$];
  int out_eng [$];
  int out_cyc [$];

  logic          s_fb_rts;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_data;
  logic [N-1:0]  s_rtr;
  logic [GRANT_W-1:0] s_grant;
  logic          s_busy;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [AW-1:0] addr_of(input int e, input int s);
    return AW'((e << 16) | (s & 16'hFFFF));
  endfunction

  function automatic logic [DW-1:0] data_of(input int e, input int s);
    return DW'(s * 7 + e * 31 + 3);
  endfunction

  task automatic drive_inputs();
    for (int e = 0; e < N; e++) begin
      bus.req_rts[e]             = (rem[e] > 0);
      bus.req_last[e]            = use_last[e] && (rem[e] == 1);
      bus.req_addr[e*AW +: AW]   = addr_of(e, seq[e]);
      bus.req_data[e*DW +: DW]   = data_of(e, seq[e]);
    end
  endtask

  task automatic load(input int e, input int n, input bit last);
    rem[e]      = n;
    use_last[e] = last;
    drive_inputs();
  endtask

  task automatic clear_model();
    for (int e = 0; e < N; e++) begin
      rem[e] = 0;
      fire_cyc[e] = -1;
      sb[e].delete();
    end
    out_eng.delete();
    out_cyc.delete();
    drive_inputs();
  endtask

  // One clock: sample at negedge, score outputs, advance engines after posedge
  task automatic step();
    logic [N-1:0] fire;
    int eng;
    @(negedge clk);
    s_fb_rts = bus.fb_rts;
    s_addr   = bus.fb_addr;
    s_data   = bus.fb_data;
    s_rtr    = bus.req_rtr;
    s_grant  = grant_id;
    s_busy   = busy;
    fire     = bus.req_rts & bus.req_rtr;
    check_val("rtr_onehot0", 32'($onehot0(s_rtr)), 32'd1);
    if (s_fb_rts && bus.fb_rtr) begin
      eng = int'(s_addr[AW-1:16]);
      if (eng < N && sb[eng].size() != 0)
        check_val("sb_beat", 32'({s_addr, s_data}), sb[eng].pop_front());
      else
        check_val("sb_stray", 32'({s_addr, s_data}), 32'hFFFF_FFFF);
      out_eng.push_back(eng);
      out_cyc.push_back(cyc);
    end
    for (int e = 0; e < N; e++) begin
      if (fire[e]) begin
        sb[e].push_back(32'({addr_of(e, seq[e]), data_of(e, seq[e])}));
        fire_cyc[e] = cyc;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int e = 0; e < N; e++) begin
      if (fire[e]) begin
        seq[e]++;
        rem[e]--;
      end
    end
    drive_inputs();
  endtask

  function automatic bit all_idle();
    bit r;
    r = !bus.fb_rts;
    for (int e = 0; e < N; e++)
      if (rem[e] != 0 || sb[e].size() != 0) r = 1'b0;
    return r;
  endfunction

  task automatic drain(input string tag, input int limit);
    int n;
    bit done;
    n = 0;
    done = all_idle();
    while (!done && n < limit) begin
      step();
      n++;
      done = all_idle();
    end
    check_val(tag, 32'(done), 32'd1);
  endtask

  task automatic wait_outs(input string tag, input int cnt, input int limit);
    int n;
    n = 0;
    while (out_eng.size() < cnt && n < limit) begin
      step();
      n++;
    end
    check_val(tag, 32'(out_eng.size() >= cnt), 32'd1);
  endtask

  task automatic do_reset();
    rst_ = 1'b0;
    soft_reset = 1'b0;
    bus.fb_rtr = 1'b1;
    clear_model();
    step();
    step();
    rst_ = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int exp_eng [$];
    int run_eng [$];
    int run_len [$];
    logic [AW-1:0] hold_addr;
    logic [DW-1:0] hold_data;
    int p, n;

    for (int e = 0; e < N; e++) begin
      seq[e] = 0;
      use_last[e] = 1'b0;
    end
    bus.fb_rtr = 1'b1;
    clear_model();

    // Reset values, then mid-burst asynchronous reset
    step();
    check_val("rst_fb_rts", 32'(s_fb_rts), 0);
    check_val("rst_fb_addr", 32'(s_addr), 0);
    check_val("rst_fb_data", 32'(s_data), 0);
    check_val("rst_rtr", 32'(s_rtr), 0);
    check_val("rst_grant", 32'(s_grant), 0);
    check_val("rst_busy", 32'(s_busy), 0);
    rst_ = 1'b1;
    load(3, 6, 1); load(1, 6, 1); load(0, 6, 1);
    wait_outs("t1_wait", 3, 50);
    if (out_eng.size() > 0) check_val("t1_first_owner", 32'(out_eng[0]), 0);
    rst_ = 1'b0;
    clear_model();
    step();
    check_val("t1_mid_fb_rts", 32'(s_fb_rts), 0);
    check_val("t1_mid_fb_addr", 32'(s_addr), 0);
    check_val("t1_mid_fb_data", 32'(s_data), 0);
    check_val("t1_mid_rtr", 32'(s_rtr), 0);
    check_val("t1_mid_busy", 32'(s_busy), 0);
    rst_ = 1'b1;
    load(3, 4, 1); load(1, 4, 1); load(0, 4, 1);
    wait_outs("t1_wait2", 1, 50);
    if (out_eng.size() > 0) check_val("t1_post_first", 32'(out_eng[0]), 0);
    drain("t1_drain", 100);

    // Round-robin among 0,2,4 with 3-beat primitives
    do_reset();
    load(0, 3, 1); load(2, 3, 1); load(4, 3, 1);
    drain("t2_drain", 100);
    check_val("t2_count", 32'(out_eng.size()), 9);
    for (int i = 0; i < 9 && i < out_eng.size(); i++) begin
      check_val("t2_order", 32'(out_eng[i]), 32'((i / 3) * 2));
      if (i > 0)
        check_val("t2_gap", 32'(out_cyc[i] - out_cyc[i-1]), (i % 3 == 0) ? 32'd2 : 32'd1);
    end

    // Burst cap: 1 streams 40, 3 streams 32, neither marks last
    do_reset();
    load(1, 40, 0); load(3, 32, 0);
    drain("t3_drain", 400);
    for (int i = 0; i < out_eng.size(); i++) begin
      if (i == 0 || out_eng[i] != out_eng[i-1]) begin
        run_eng.push_back(out_eng[i]);
        run_len.push_back(1);
      end else begin
        run_len[run_len.size()-1]++;
      end
    end
    exp_eng = '{1, 3, 1, 3, 1};
    check_val("t3_runs", 32'(run_eng.size()), 5);
    for (int i = 0; i < 5 && i < run_eng.size(); i++) begin
      check_val("t3_run_eng", 32'(run_eng[i]), 32'(exp_eng[i]));
      check_val("t3_run_len", 32'(run_len[i]), (i == 4) ? 32'd8 : 32'd16);
    end

    // Backpressure mid-grant with a waiting non-owner
    do_reset();
    load(2, 10, 1); load(4, 3, 1);
    wait_outs("t4_wait", 3, 50);
    bus.fb_rtr = 1'b0;
    step();
    check_val("t4_hold_rts", 32'(s_fb_rts), 1);
    check_val("t4_hold_rtr", 32'(s_rtr), 0);
    hold_addr = s_addr;
    hold_data = s_data;
    n = out_eng.size();
    for (int k = 0; k < 4; k++) begin
      step();
      check_val("t4_addr_stable", 32'(s_addr), 32'(hold_addr));
      check_val("t4_data_stable", 32'(s_data), 32'(hold_data));
      check_val("t4_stall_rtr", 32'(s_rtr), 0);
    end
    check_val("t4_no_out_stalled", 32'(out_eng.size()), 32'(n));
    bus.fb_rtr = 1'b1;
    drain("t4_drain", 100);
    check_val("t4_total", 32'(out_eng.size()), 13);

    // Idle timeout: owner 2 goes quiet after 2 beats, engine 0 waiting
    do_reset();
    load(2, 2, 0);
    n = 0;
    while (rem[2] != 0 && n < 20) begin step(); n++; end
    check_val("t5_two_beats", 32'(rem[2]), 0);
    p = fire_cyc[2];
    load(0, 2, 1);
    for (int k = 0; k < 5; k++) step();
    check_val("t5_still_owner", 32'(s_grant), 2);
    check_val("t5_busy_idle", 32'(s_busy), 1);
    n = 0;
    while (fire_cyc[0] < 0 && n < 30) begin step(); n++; end
    check_val("t5_release_lat", 32'(fire_cyc[0] - p), 10);
    drain("t5_drain", 50);

    // Soft reset with a held beat under backpressure
    do_reset();
    load(1, 6, 1);
    wait_outs("t6_wait", 2, 30);
    bus.fb_rtr = 1'b0;
    step();
    step();
    check_val("t6_held", 32'(s_fb_rts), 1);
    check_val("t6_pending", 32'(sb[1].size()), 1);
    soft_reset = 1'b1;
    step();
    soft_reset = 1'b0;
    if (sb[1].size() != 0) void'(sb[1].pop_front());
    step();
    check_val("t6_fb_rts", 32'(s_fb_rts), 0);
    check_val("t6_busy", 32'(s_busy), 0);
    check_val("t6_grant", 32'(s_grant), 0);
    check_val("t6_rtr", 32'(s_rtr), 0);
    bus.fb_rtr = 1'b1;
    drain("t6_drain", 60);
    check_val("t6_total", 32'(out_eng.size()), 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_fb_write_arbiter
`default_nettype wire
